// File: rtl/sonar_pkg.sv
// Shared sonar definitions: ping sequencer states and the default counter width
// used by both the sequencer and the downstream time-of-flight consumer.
package sonar_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_BURST,
    ST_BLANK,
    ST_LISTEN,
    ST_REPORT
  } ping_state_t;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous comparator input, plus one history
// flop so a single-cycle rising-edge pulse can be produced in the clk domain.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  // sync_reg[0] is the metastability catcher; rise is taken from [1] vs [2]
  logic [2:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], async_in};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/ping_ctrl.sv
// Sonar ping sequencer: gates the tone into a burst of whole periods, blanks
// ring-down, then times the first echo edge and hands the result over valid/ready.
module ping_ctrl
  import sonar_pkg::*;
#(
  parameter int unsigned BURST_CYCLES = 8,
  parameter int unsigned BLANK_CLKS   = 1000,
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wave_in,
  input  logic             start,
  input  logic             echo_in,
  output logic             tx_out,
  output logic             tx_en,
  output logic             busy,
  output logic [CNT_W-1:0] tof,
  output logic             tof_timeout,
  output logic             tof_valid,
  input  logic             tof_ready
);

  localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CLKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  ping_state_t      state_reg, state_next;
  logic             wave_d_reg;
  logic             tx_out_reg, tx_out_next;
  logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
  logic [CNT_W-1:0] blank_cnt_reg, blank_cnt_next;
  logic [CNT_W-1:0] tof_cnt_reg, tof_cnt_next;
  logic [CNT_W-1:0] tof_reg, tof_next;
  logic             tof_timeout_reg, tof_timeout_next;
  logic             wave_rise;
  logic             echo_rise;

  echo_sync u_echo_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (echo_in),
    .rise     (echo_rise)
  );

  assign wave_rise = wave_in & ~wave_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      wave_d_reg      <= 1'b0;
      tx_out_reg      <= 1'b0;
      edge_cnt_reg    <= '0;
      blank_cnt_reg   <= '0;
      tof_cnt_reg     <= '0;
      tof_reg         <= '0;
      tof_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wave_d_reg      <= wave_in;
      tx_out_reg      <= tx_out_next;
      edge_cnt_reg    <= edge_cnt_next;
      blank_cnt_reg   <= blank_cnt_next;
      tof_cnt_reg     <= tof_cnt_next;
      tof_reg         <= tof_next;
      tof_timeout_reg <= tof_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    tx_out_next      = 1'b0;
    edge_cnt_next    = edge_cnt_reg;
    blank_cnt_next   = blank_cnt_reg;
    tof_cnt_next     = tof_cnt_reg;
    tof_next         = tof_reg;
    tof_timeout_next = tof_timeout_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_ALIGN;
      end
      ST_ALIGN: begin
        // Burst starts on a tone edge so the first emitted period is whole
        if (wave_rise) begin
          state_next    = ST_BURST;
          tof_cnt_next  = '0;
          edge_cnt_next = CNT_ONE;
          tx_out_next   = wave_in;
        end
      end
      ST_BURST: begin
        tof_cnt_next = tof_cnt_reg + CNT_ONE;
        tx_out_next  = wave_in;
        if (wave_rise) begin
          if (edge_cnt_reg == BURST_LAST) begin
            state_next     = ST_BLANK;
            tx_out_next    = 1'b0;
            blank_cnt_next = '0;
          end else begin
            edge_cnt_next = edge_cnt_reg + CNT_ONE;
          end
        end
      end
      ST_BLANK: begin
        tof_cnt_next = tof_cnt_reg + CNT_ONE;
        if (blank_cnt_reg == BLANK_LAST) begin
          state_next = ST_LISTEN;
        end else begin
          blank_cnt_next = blank_cnt_reg + CNT_ONE;
        end
      end
      ST_LISTEN: begin
        tof_cnt_next = tof_cnt_reg + CNT_ONE;
        // An echo landing on the timeout cycle still counts as a real echo
        if (echo_rise) begin
          state_next       = ST_REPORT;
          tof_next         = tof_cnt_reg;
          tof_timeout_next = 1'b0;
        end else if (tof_cnt_reg == TIMEOUT_LAST) begin
          state_next       = ST_REPORT;
          tof_next         = TIMEOUT_VAL;
          tof_timeout_next = 1'b1;
        end
      end
      ST_REPORT: begin
        if (tof_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign tx_out      = tx_out_reg;
  assign tx_en       = (state_reg == ST_BURST);
  assign busy        = (state_reg != ST_IDLE);
  assign tof         = tof_reg;
  assign tof_timeout = tof_timeout_reg;
  assign tof_valid   = (state_reg == ST_REPORT);

endmodule

// File: tb/tb_ping_ctrl.sv
// Bench for ping_ctrl: timeline reference model with per-cycle compare, plus
// directed boundary pings with literal expectations and a randomized ping loop.
module tb_ping_ctrl;

  localparam int BC  = 3;
  localparam int BL  = 20;
  localparam int TO  = 200;
  localparam int PER = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        wave_in = 1'b0;
  logic        start;
  logic        echo_in;
  logic        tof_ready;
  logic        tx_out, tx_en, busy, tof_timeout, tof_valid;
  logic [31:0] tof;

  ping_ctrl #(
    .BURST_CYCLES (BC),
    .BLANK_CLKS   (BL),
    .TIMEOUT_CLKS (TO),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wave_in     (wave_in),
    .start       (start),
    .echo_in     (echo_in),
    .tx_out      (tx_out),
    .tx_en       (tx_en),
    .busy        (busy),
    .tof         (tof),
    .tof_timeout (tof_timeout),
    .tof_valid   (tof_valid),
    .tof_ready   (tof_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Tone generator: period PER, 50% duty, changes away from the sampling edge
  int wave_ph = 0;
  always @(negedge clk) begin
    wave_ph = (wave_ph + 1) % PER;
    wave_in = (wave_ph < PER / 2);
  end

  // ---------------- reference model (absolute-time bookkeeping) ----------------
  typedef enum int {M_IDLE, M_ALIGN, M_BURST, M_BLANK, M_LISTEN, M_REPORT} mode_t;
  mode_t mode = M_IDLE;
  int    cyc = 0;          // number of clock edges seen
  int    m_t0 = 0;         // edge after which tof_cnt reads 0
  int    m_rises = 0;
  int    m_listen_at = 0;
  int    m_tof = 0;
  bit    m_to = 1'b0;
  bit    m_tx_out = 1'b0;
  bit    w_prev = 1'b0;
  bit    e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;   // echo samples at edges k-1, k-2, k-3

  always @(posedge clk) begin
    bit w_rise, e_rise;
    int cnt;
    cyc++;
    w_rise = wave_in && !w_prev;
    e_rise = e2 && !e3;
    cnt    = cyc - 1 - m_t0;   // tof_cnt of the cycle this edge closes
    if (rst) begin
      mode  = M_IDLE;
      m_tof = 0;
      m_to  = 1'b0;
    end else begin
      case (mode)
        M_IDLE:   if (start) mode = M_ALIGN;
        M_ALIGN:  if (w_rise) begin mode = M_BURST; m_t0 = cyc; m_rises = 0; end
        M_BURST:  if (w_rise) begin
                    m_rises++;
                    if (m_rises == BC) begin mode = M_BLANK; m_listen_at = cyc + BL; end
                  end
        M_BLANK:  if (cyc == m_listen_at) mode = M_LISTEN;
        M_LISTEN: if (e_rise) begin
                    mode = M_REPORT; m_tof = cnt; m_to = 1'b0;
                  end else if (cnt == TO - 1) begin
                    mode = M_REPORT; m_tof = TO; m_to = 1'b1;
                  end
        M_REPORT: if (tof_ready) mode = M_IDLE;
        default:  mode = M_IDLE;
      endcase
    end
    m_tx_out = (mode == M_BURST) && wave_in;
    e3 = e2;
    e2 = e1;
    e1 = echo_in && !rst;
    w_prev = wave_in && !rst;
  end

  // Per-cycle compare, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    chk("busy", busy, (mode != M_IDLE));
    chk("tx_en", tx_en, (mode == M_BURST));
    chk("tx_out", tx_out, m_tx_out);
    chk("tof_valid", tof_valid, (mode == M_REPORT));
    if (mode == M_REPORT) begin
      chk("tof", tof, m_tof);
      chk("tof_timeout", tof_timeout, m_to);
    end
  end

  // Burst-shape monitor
  bit mon_en = 1'b0;
  int en_cnt, hi_cnt, pulse_cnt, bad_cnt;
  bit tx_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_en) en_cnt++;
      if (tx_out) hi_cnt++;
      if (tx_out && !tx_prev) pulse_cnt++;
      if (tx_out && !tx_en) bad_cnt++;
    end
    tx_prev = tx_out;
  end

  int ping_no = 0;

  // Called at a negedge with DUT idle; returns in the cycle after the handshake edge.
  task automatic ping(input int echo_at, input int echo_len, input int ready_delay,
                      output int got_tof, output bit got_to);
    int n, cur;
    got_tof = -1;
    got_to  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_accepted", busy, 1);
    for (n = 0; n < TO + 100 && !tof_valid; n++) begin
      if (mode inside {M_BURST, M_BLANK, M_LISTEN}) begin
        cur = cyc - m_t0;
        if (echo_at >= 0 && cur == echo_at) echo_in = 1'b1;
        if (echo_at >= 0 && cur == echo_at + echo_len) echo_in = 1'b0;
      end
      @(negedge clk);
    end
    echo_in = 1'b0;
    if (!tof_valid) begin
      chk("ping_completes", tof_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    got_tof = tof;
    got_to  = tof_timeout;
    for (int d = 0; d < ready_delay; d++) begin
      start = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    tof_ready = 1'b1;
    @(negedge clk);
    tof_ready = 1'b0;
    ping_no++;
    $display("ping %0d: echo_at=%0d len=%0d ready_delay=%0d -> tof=%0d timeout=%0d",
             ping_no, echo_at, echo_len, ready_delay, got_tof, got_to);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit to;
    rst = 1'b1; start = 1'b0; echo_in = 1'b0; tof_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tof", tof, 0);
    chk("rst_tof_timeout", tof_timeout, 0);
    chk("rst_tof_valid", tof_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic ping with burst-shape measurement
    en_cnt = 0; hi_cnt = 0; pulse_cnt = 0; bad_cnt = 0;
    mon_en = 1'b1;
    ping(100, 5, 0, t, to);
    mon_en = 1'b0;
    chk("basic_tof", t, 102);
    chk("basic_timeout", to, 0);
    chk("burst_tx_en_cycles", en_cnt, BC * PER);
    chk("burst_pulses", pulse_cnt, BC);
    chk("burst_high_cycles", hi_cnt, BC * PER / 2);
    chk("burst_tx_out_outside_en", bad_cnt, 0);

    // Echo only inside blanking: ignored, times out
    repeat (3) @(negedge clk);
    ping(35, 5, 0, t, to);
    chk("blank_echo_tof", t, TO);
    chk("blank_echo_timeout", to, 1);

    // Backpressure, then back-to-back start on the first idle cycle
    ping(60, 3, 10, t, to);
    chk("bp_tof", t, 62);
    chk("bp_idle_after_hs", busy, 0);
    ping(80, 3, 0, t, to);
    chk("b2b_tof", t, 82);

    // Reset during the second tone period of the burst
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && !(mode == M_BURST && cyc - m_t0 == 12); n++) @(negedge clk);
    chk("pre_rst_tx_out", tx_out, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_out", tx_out, 0);
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ping(120, 4, 1, t, to);
    chk("post_rst_tof", t, 122);

    // Listen-window boundaries
    ping(TO - 3, 5, 0, t, to);
    chk("echo_on_timeout_tof", t, TO - 1);
    chk("echo_on_timeout_flag", to, 0);
    ping(TO - 2, 5, 0, t, to);
    chk("echo_after_timeout_tof", t, TO);
    chk("echo_after_timeout_flag", to, 1);
    ping(BC * PER + BL - 2, 3, 0, t, to);
    chk("first_listen_tof", t, BC * PER + BL);
    ping(BC * PER + BL - 3, 30, 0, t, to);
    chk("last_blank_tof", t, TO);
    chk("last_blank_flag", to, 1);

    // Randomized pings
    for (int i = 0; i < 20; i++) begin
      int ea, el, rd;
      repeat ($urandom_range(0, PER - 1)) @(negedge clk);
      ea = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO + 20));
      el = $urandom_range(1, 20);
      rd = $urandom_range(0, 6);
      ping(ea, el, rd, t, to);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ping_ctrl.md
# ping_ctrl

Sonar transmit/receive sequencer that sits directly downstream of the square-wave tone generator. It gates the free-running tone into a burst of a fixed number of whole periods for the transducer driver, then blanks out transducer ring-down. After that it listens for the first echo-comparator rising edge and reports time-of-flight in clock cycles, measured from burst start. The result is delivered through a valid/ready handshake, with a timeout flag if no echo arrives.

## Interface
- BURST_CYCLES, 8: tone periods (wave_in rising edges) per burst; ≥1
- BLANK_CLKS, 1000: clocks after burst end during which echo is ignored; ≥1
- TIMEOUT_CLKS, 1000000: tof counter value that ends listening; must exceed burst length + BLANK_CLKS and fit CNT_W
- CNT_W, 32: width of tof and internal counters
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- wave_in  in  1  tone square wave from generator, synchronous to clk
- start  in  1  single-cycle ping request; ignored unless IDLE
- echo_in  in  1  raw echo comparator output, asynchronous
- tx_out  out  1  gated tone to transducer driver (registered)
- tx_en  out  1  high while burst active (driver enable)
- busy  out  1  high in every state except IDLE
- tof  out  CNT_W  time of flight in clk cycles; stable while tof_valid
- tof_timeout  out  1  qualifies tof: no echo before TIMEOUT_CLKS
- tof_valid  out  1  result available
- tof_ready  in  1  consumer accepts result

## Operation
- States: IDLE, ALIGN, BURST, BLANK, LISTEN, REPORT.
- wave rise = wave_in & ~wave_d, where wave_d is wave_in registered once. echo rise = s2 & ~s3 on a 3-flop chain (2-flop sync plus history).
- IDLE: start=1 → ALIGN.
- ALIGN: on a wave rise → BURST; tof_cnt←0; edge_cnt←1. This gives phase-clean burst start.
- BURST: tx_en=1; tx_out←wave_in each cycle. Each wave rise: if edge_cnt==BURST_CYCLES → BLANK and tx_out←0, else edge_cnt+1. Exactly BURST_CYCLES full periods are emitted.
- BLANK: blank_cnt counts 0..BLANK_CLKS-1, then → LISTEN. Echo rises are discarded.
- LISTEN:
  - echo rise → REPORT; tof←tof_cnt; tof_timeout←0.
  - Else if tof_cnt==TIMEOUT_CLKS-1 → REPORT; tof←TIMEOUT_CLKS; tof_timeout←1.
  - Same cycle: echo wins.
- tof_cnt increments every cycle in BURST, BLANK and LISTEN; it never wraps, because timeout precedes overflow.
- REPORT: tof_valid=1; tof and tof_timeout held. On tof_valid&tof_ready → IDLE. start is ignored.
- Reset values: tx_out 0, tx_en 0, busy 0, tof 0, tof_timeout 0, tof_valid 0. State is IDLE and all counters and sync flops are 0.
- rst mid-operation: every output returns to its reset value on the next clock edge. Any pending result is lost.

## Timing
- start→busy: 1 cycle. ALIGN lasts until the next wave rise, at most one tone period.
- tx_out lags wave_in by 1 cycle. The first BURST cycle has tx_out=1 and tof_cnt=0, which is the tof time reference.
- Echo path latency is a fixed 2 cycles and is not compensated. If echo_in first rises and is sampled at the end of the cycle where tof_cnt=N, then tof=N+2.
- tof_valid asserts the cycle after the capture. It clears the cycle after the handshake, when busy also drops. A start on that cycle is accepted.
- tx_en deasserts on the first cycle after the terminating wave rise.

## Structure
- sonar_pkg: ping_state_t enum and the CNT_W default constant, shared with the downstream tof consumer.
- Sub-module echo_sync: 3-flop synchronizer plus rising-edge pulse, with synchronous active-high reset. Reused for other async comparator inputs.

## Test plan
All scenarios use a tone period of 10 clk, BURST_CYCLES=3, BLANK_CLKS=20 and TIMEOUT_CLKS=200.
- Basic ping: start, then echo_in rises when tof_cnt=100 → tof=102, tof_timeout=0, tof_valid=1.
- Burst shape: tx_out shows exactly 3 pulses of 5 clk each. tx_en is high for 30 cycles and tx_out is 0 outside tx_en.
- Echo pulse during BLANK only → ignored. Later: tof_timeout=1, tof=200.
- Backpressure: tof_ready low for 10 cycles → tof stable and start ignored. Then ready → busy=0 the next cycle, and a new start is accepted.
- rst asserted during the second burst period → next cycle tx_out=0, tx_en=0, busy=0. A subsequent ping then completes normally.
- Echo rise on the timeout cycle (tof_cnt=199) → tof=199, tof_timeout=0.
